// File: rtl/mac_pkg.sv
// Shared opcodes and width helpers for the multi-lane MAC engine.
package mac_pkg;

    localparam int unsigned MAC_OP_NOP   = 0;
    localparam int unsigned MAC_OP_ACC   = 1;
    localparam int unsigned MAC_OP_LOAD  = 2;
    localparam int unsigned MAC_OP_CLEAR = 3;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

    // Full-precision width of a LANES-wide dot product.
    function automatic int unsigned sum_width(input int unsigned in_bit,
                                              input int unsigned weight_bit,
                                              input int unsigned lanes);
        return in_bit + weight_bit + clog2(lanes);
    endfunction

endpackage

// File: rtl/mac_sum_tree.sv
// Registered signed adder tree over LANES packed products (pipeline stage S).
module mac_sum_tree
    import mac_pkg::*;
#(
    parameter int unsigned PROD_BIT = 16,
    parameter int unsigned LANES    = 4,
    parameter int unsigned SUM_BIT  = PROD_BIT + clog2(LANES)
) (
    input  logic                        clk,
    input  logic [LANES*PROD_BIT-1:0]   prod_i,
    output logic signed [SUM_BIT-1:0]   sum_o
);

    localparam int unsigned LEVELS = clog2(LANES);

    // Operand count at a level; an odd leftover passes straight through.
    function automatic int unsigned lvl_cnt(input int unsigned l);
        return (LANES + (1 << l) - 1) >> l;
    endfunction

    logic signed [SUM_BIT-1:0] node [LEVELS+1][LANES+1];
    logic signed [SUM_BIT-1:0] sum_q;

    always_comb begin
        for (int unsigned l = 0; l <= LEVELS; l++)
            for (int unsigned i = 0; i <= LANES; i++)
                node[l][i] = '0;
        for (int unsigned i = 0; i < LANES; i++)
            node[0][i] = SUM_BIT'($signed(prod_i[i*PROD_BIT +: PROD_BIT]));
        for (int unsigned l = 0; l < LEVELS; l++) begin
            for (int unsigned i = 0; i < (LANES + 1) / 2; i++) begin
                if (2*i + 1 < lvl_cnt(l))
                    node[l+1][i] = node[l][2*i] + node[l][2*i+1];
                else if (2*i < lvl_cnt(l))
                    node[l+1][i] = node[l][2*i];
            end
        end
    end

    always_ff @(posedge clk) begin
        sum_q <= node[LEVELS][0];
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mac_dot_acc.sv
// Multi-lane dot-product MAC: product stage P, adder-tree stage S, accumulate stage A.
// Define MAC_SAT_EN to saturate ACC instead of wrapping.
module mac_dot_acc
    import mac_pkg::*;
#(
    parameter int unsigned IN_BIT     = 8,
    parameter int unsigned WEIGHT_BIT = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned OUT_BIT    = 24,
    parameter int unsigned OP_BIT     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic [OP_BIT-1:0]               op,
    input  logic [LANES*IN_BIT-1:0]         data_in,
    input  logic [LANES*WEIGHT_BIT-1:0]     weight,
    output logic signed [OUT_BIT-1:0]       data_out,
    output logic                            out_valid,
    output logic                            ovf
);

    localparam int unsigned PROD_BIT = IN_BIT + WEIGHT_BIT;
    localparam int unsigned SUM_BIT  = sum_width(IN_BIT, WEIGHT_BIT, LANES);
    localparam int unsigned WIDE_BIT = OUT_BIT + 1;

    logic [LANES*PROD_BIT-1:0]  prod_c;
    logic signed [PROD_BIT-1:0] a_s, w_s;

    logic [LANES*PROD_BIT-1:0]  p_prod_q;
    logic [OP_BIT-1:0]          p_op_q, s_op_q;
    logic                       p_vld_q, p_last_q, s_vld_q, s_last_q;
    logic signed [SUM_BIT-1:0]  sum_s;

    logic signed [OUT_BIT-1:0]  acc_q, acc_d, ext_c;
    logic signed [WIDE_BIT-1:0] wide_c;
    logic                       ovf_q, ovf_d, vld_q, vld_d, acc_ovf_c;

    // Operands are widened before multiplying so the product is exact.
    always_comb begin
        prod_c = '0;
        a_s    = '0;
        w_s    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            a_s = PROD_BIT'($signed(data_in[i*IN_BIT +: IN_BIT]));
            w_s = PROD_BIT'($signed(weight[i*WEIGHT_BIT +: WEIGHT_BIT]));
            prod_c[i*PROD_BIT +: PROD_BIT] = a_s * w_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
        end else begin
            p_vld_q <= in_valid;
            s_vld_q <= p_vld_q;
        end
        p_prod_q <= prod_c;
        p_op_q   <= op;
        p_last_q <= in_last;
        s_op_q   <= p_op_q;
        s_last_q <= p_last_q;
    end

    mac_sum_tree #(
        .PROD_BIT (PROD_BIT),
        .LANES    (LANES),
        .SUM_BIT  (SUM_BIT)
    ) u_sum_tree (
        .clk    (clk),
        .prod_i (p_prod_q),
        .sum_o  (sum_s)
    );

    // Sum always fits OUT_BIT, so sign extension itself never clips.
    assign ext_c     = OUT_BIT'(sum_s);
    assign wide_c    = WIDE_BIT'(acc_q) + WIDE_BIT'(ext_c);
    assign acc_ovf_c = wide_c[OUT_BIT] ^ wide_c[OUT_BIT-1];

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        vld_d = s_vld_q & s_last_q;
        if (s_vld_q) begin
            case (s_op_q)
                OP_BIT'(MAC_OP_ACC): begin
                    acc_d = wide_c[OUT_BIT-1:0];
                    ovf_d = ovf_q | acc_ovf_c;
`ifdef MAC_SAT_EN
                    if (acc_ovf_c)
                        acc_d = wide_c[OUT_BIT] ? {1'b1, {(OUT_BIT-1){1'b0}}}
                                                : {1'b0, {(OUT_BIT-1){1'b1}}};
`endif
                end
                OP_BIT'(MAC_OP_LOAD): begin
                    acc_d = ext_c;
                    ovf_d = 1'b0;
                end
                OP_BIT'(MAC_OP_CLEAR): begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign data_out  = acc_q;
    assign out_valid = vld_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_dot_acc.sv
// Scoreboard bench for mac_dot_acc with a plain-arithmetic dot-product model.
module tb_mac_dot_acc;
    import mac_pkg::*;

    localparam int unsigned IN_BIT     = 8;
    localparam int unsigned WEIGHT_BIT = 8;
    localparam int unsigned LANES      = 4;
    localparam int unsigned OUT_BIT    = 20;
    localparam int unsigned OP_BIT     = 2;
    localparam longint MAX_V = (longint'(1) <<< (OUT_BIT-1)) - 1;
    localparam longint MIN_V = -(longint'(1) <<< (OUT_BIT-1));
    localparam longint MOD_V = longint'(1) <<< OUT_BIT;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            in_valid, in_last;
    logic [OP_BIT-1:0]               op;
    logic [LANES*IN_BIT-1:0]         data_in;
    logic [LANES*WEIGHT_BIT-1:0]     weight;
    logic signed [OUT_BIT-1:0]       data_out;
    logic                            out_valid, ovf;

    mac_dot_acc #(
        .IN_BIT(IN_BIT), .WEIGHT_BIT(WEIGHT_BIT), .LANES(LANES),
        .OUT_BIT(OUT_BIT), .OP_BIT(OP_BIT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .op(op), .data_in(data_in), .weight(weight),
        .data_out(data_out), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { longint val; bit ovf; int cyc; } exp_t;
    exp_t q[$];

    longint m_acc = 0;
    bit     m_ovf = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic longint dot(input logic [31:0] d, input logic [31:0] w);
        logic signed [7:0] x, y;
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            x = d[i*8 +: 8];
            y = w[i*8 +: 8];
            s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    task automatic model(input logic [1:0] o, input longint s);
        longint w;
        case (int'(o))
            MAC_OP_ACC: begin
                w = m_acc + s;
                if (w > MAX_V || w < MIN_V) begin
                    m_ovf = 1'b1;
`ifdef MAC_SAT_EN
                    w = (w > MAX_V) ? MAX_V : MIN_V;
`else
                    w = (w > MAX_V) ? w - MOD_V : w + MOD_V;
`endif
                end
                m_acc = w;
            end
            MAC_OP_LOAD:  begin m_acc = s; m_ovf = 1'b0; end
            MAC_OP_CLEAR: begin m_acc = 0; m_ovf = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic beat(input int o, input bit last, input logic [31:0] d,
                        input logic [31:0] w, input bit track = 1'b1);
        in_valid = 1'b1;
        in_last  = last;
        op       = 2'(o);
        data_in  = d;
        weight   = w;
        if (track) begin
            model(2'(o), dot(d, w));
            if (last) q.push_back('{m_acc, m_ovf, cyc + 3});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        op       = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every out_valid must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got data_out=%0d with no pending result (t=%0t)",
                         data_out, $time);
            end else begin
                e = q.pop_front();
                check("data_out", longint'(data_out), e.val);
                check("ovf", longint'(ovf), longint'(e.ovf));
                check("latency_cycle", longint'(cyc), longint'(e.cyc));
            end
        end
    end

    initial begin
        logic [31:0] ones, neg, d, w;
        longint ref_sum;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; op = '0;
        data_in = '0; weight = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_data_out", longint'(data_out), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_ovf", longint'(ovf), 0);
        @(posedge clk); #1;

        beat(MAC_OP_LOAD, 1'b1, pack4(1,2,3,4), pack4(5,6,7,8));
        idle(4);
        check("load_70", longint'(data_out), 70);

        ones = pack4(1,1,1,1);
        beat(MAC_OP_LOAD, 1'b0, ones, ones);
        for (int i = 0; i < 3; i++) beat(MAC_OP_ACC, i == 2, ones, ones);
        idle(4);
        check("chain_16", longint'(data_out), 16);

        // ACC stream with bubbles and NOPs must match the bubble-free sum.
        beat(MAC_OP_CLEAR, 1'b0, '0, '0);
        ref_sum = 0;
        for (int i = 0; i < 12; i++) begin
            d = pack4($urandom_range(0,15)-8, $urandom_range(0,15)-8,
                      $urandom_range(0,15)-8, $urandom_range(0,15)-8);
            w = pack4($urandom_range(0,15)-8, $urandom_range(0,15)-8,
                      $urandom_range(0,15)-8, $urandom_range(0,15)-8);
            ref_sum += dot(d, w);
            beat(MAC_OP_ACC, i == 11, d, w);
            if (i != 11) begin
                idle($urandom_range(0,2));
                if ($urandom_range(0,1) == 1)
                    beat(MAC_OP_NOP, 1'b0, pack4(100,-90,7,3), pack4(50,60,-70,1));
            end
        end
        idle(4);
        check("bubble_sum", longint'(data_out), ref_sum);

        // Repeated extreme ACC drives the accumulator past full scale.
        neg = pack4(-128,-128,-128,-128);
        beat(MAC_OP_CLEAR, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) beat(MAC_OP_ACC, 1'b1, neg, neg);
        idle(4);
`ifdef MAC_SAT_EN
        check("overflow_value", longint'(data_out), 524287);
`else
        check("overflow_value", longint'(data_out), -393216);
`endif
        check("overflow_flag", longint'(ovf), 1);

        // Reset with two beats in flight, one marked last.
        beat(MAC_OP_ACC, 1'b0, neg, neg, 1'b0);
        beat(MAC_OP_ACC, 1'b1, neg, neg, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        check("flush_data_out", longint'(data_out), 0);
        check("flush_ovf", longint'(ovf), 0);
        idle(4);
        check("flush_data_out_late", longint'(data_out), 0);
        beat(MAC_OP_LOAD, 1'b1, pack4(2,0,0,0), pack4(3,0,0,0));
        idle(4);
        check("post_reset_load", longint'(data_out), 6);

        // Random mixed traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0,3) == 0) idle(1);
            d = $urandom();
            w = $urandom();
            beat(($urandom_range(0,9) < 6) ? MAC_OP_ACC : int'($urandom_range(0,3)),
                 $urandom_range(0,3) == 0, d, w);
        end
        beat(MAC_OP_NOP, 1'b1, '0, '0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_dot_acc.md
# mac_dot_acc

Parametrised multi-lane multiply-accumulate engine; next generation of the single-lane `MAC`. Each accepted beat multiplies `LANES` signed data/weight pairs, sums the products and applies an opcode to a signed accumulator: accumulate, load, clear or no-op. The block is fully pipelined at one beat per clock with a `last` marker that emits a result-valid pulse. It sits between the feature/weight buffers and the output/activation stage of the convolution datapath.

## Interface
- `IN_BIT`, 8, signed data width per lane
- `WEIGHT_BIT`, 8, signed weight width per lane
- `LANES`, 4, products per beat; must be at least 1
- `OUT_BIT`, 24, accumulator/output width; must be at least `IN_BIT+WEIGHT_BIT+clog2(LANES)`
- `OP_BIT`, 2, opcode width

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous reset, active-high
- `in_valid` in 1: beat present this cycle
- `in_last` in 1: final beat of a dot product; qualified by `in_valid`
- `op` in `OP_BIT`: 0 NOP, 1 ACC, 2 LOAD, 3 CLEAR
- `data_in` in `LANES*IN_BIT`: lane *i* at bits `[i*IN_BIT +: IN_BIT]`, signed
- `weight` in `LANES*WEIGHT_BIT`: same packing, signed
- `data_out` out `OUT_BIT`: accumulator register, signed
- `out_valid` out 1: one-cycle pulse when `data_out` holds a finished result
- `ovf` out 1: sticky overflow/saturation flag

## Operation
- Stage 1 (P): on `in_valid`, register the `LANES` full-precision signed products, `op` and `in_last`. The valid bit travels with the beat.
- Stage 2 (S): register the signed sum of the products through an adder tree. The sum width is `IN_BIT+WEIGHT_BIT+clog2(LANES)`, sign-extended to `OUT_BIT`.
- Stage 3 (A): apply `op` to the accumulator.
  - ACC: `acc <= acc + S`.
  - LOAD: `acc <= S`.
  - CLEAR: `acc <= 0`; S is ignored.
  - NOP: `acc` unchanged.
  - Unused encodings (if `OP_BIT>2`) behave as NOP.
- When `in_valid` is 0, the stages carry a bubble and `acc` is unchanged.
- There is no backpressure. Every valid beat is accepted.
- `out_valid` pulses when a beat with `in_last=1` completes stage A, whatever its `op`. A CLEAR marked last gives `out_valid` with `data_out=0`. A NOP marked last re-presents the current `acc`.
- Default arithmetic wraps modulo 2^`OUT_BIT` in two's complement. `ovf` sets on signed overflow of ACC.
- `ovf` clears on LOAD, CLEAR and `rst`. It holds otherwise.

## Timing
- Reset values: `data_out`=0, `out_valid`=0, `ovf`=0, and all pipeline valid bits 0.
- Latency: a beat sampled at edge T updates `data_out` at edge T+2. When that beat is marked last, `out_valid` is high for the cycle after edge T+2.
- Throughput is 1 beat per clock. Back-to-back LOAD then ACC beats chain correctly because stage A feeds back onto itself.
- Reset dominates: `rst` high at any edge discards all in-flight beats and zeroes `acc`. The first beat after reset deasserts behaves as if the pipeline were empty.
- `out_valid` never asserts for a beat that was in flight during reset.

## Configuration
- `MAC_SAT_EN` defined: ACC and the sign-extension path saturate to [-2^(`OUT_BIT`-1), 2^(`OUT_BIT`-1)-1]. `ovf` sets whenever saturation occurs.
- `MAC_SAT_EN` undefined: wrap-around arithmetic. `ovf` still reports signed ACC overflow.

## Structure
- Shared package `mac_pkg`:
  - opcode localparams `MAC_OP_NOP`, `MAC_OP_ACC`, `MAC_OP_LOAD`, `MAC_OP_CLEAR`
  - a `clog2` function
  - a sum-width helper
- One sub-module, `mac_sum_tree`: registered signed adder tree over `LANES` products. It has one register stage so that it forms stage S, and it handles odd `LANES` by passing the odd element through.
- The top module holds stage P, stage A, the opcode decode and the flag logic.

## Test plan
- Reset then LOAD last, `LANES=4`, data {1,2,3,4}, weight {5,6,7,8} → `out_valid` 3 cycles after issue, `data_out`=70.
- LOAD {1,1,1,1}·{1,1,1,1} followed by 3 back-to-back ACC beats of the same values, last on the 4th → single `out_valid`, `data_out`=16.
- Beat with data {-128,-128,-128,-128}, weight {-128,-128,-128,-128} → sum 65536. ACC it repeatedly:
  - `OUT_BIT=20` with `MAC_SAT_EN`: result 524287 and `ovf`=1.
  - Without the macro: wraps to negative and `ovf`=1.
- Interleave `in_valid`=0 bubbles and NOP beats in an ACC stream → `acc` unchanged across them, and the final value equals the bubble-free run.
- Assert `rst` for 1 cycle while 2 beats are in flight, one marked last → no `out_valid`, `data_out`=0, `ovf`=0. The next LOAD {2,0,0,0}·{3,0,0,0} last gives 6.
